// File: rtl/ahb3_pkg.sv
// Shared AHB3-Lite encodings and the responder state type.
//   HTRANS_*  : transfer type encodings
//   HSIZE_*   : transfer size encodings (log2 bytes)
//   HRESP_*   : response encodings
//   resp_state_e : responder data-phase state
package ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } resp_state_e;

endpackage

// File: rtl/ahb3_sram_array.sv
// Byte-writable word array with an asynchronous read port.
//   clk_i   : write clock
//   be_i    : per-byte write enable
//   waddr_i : write word index
//   wdata_i : write data
//   raddr_i : read word index
//   rdata_o : read data (combinational)
// Contents are deliberately not reset.
module ahb3_sram_array #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic [XLEN/8-1:0]        be_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [XLEN-1:0]          rdata_o
);

  localparam int unsigned NB = XLEN / 8;

  logic [XLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (be_i[b]) begin
        mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb3_sram_responder.sv
// AHB3-Lite responder terminating one master port with an SRAM model.
//   clk, rst        : clock, asynchronous active-high reset
//   HSEL/HADDR/HWRITE/HSIZE/HTRANS : address phase
//   HWDATA          : write data (data phase)
//   HRDATA          : read data, valid in WAIT/DATA, else 0
//   HREADY          : HREADYOUT, also the bus HREADY (point-to-point)
//   HRESP           : OKAY/ERROR
//   HBURST/HPROT/HMASTLOCK : ignored
module ahb3_sram_responder
  import ahb3_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned PLEN        = 64,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  output logic            HREADY,
  output logic            HRESP
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [PLEN-1:0] MemBytes = PLEN'(DEPTH * NB);

  resp_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q;
  logic [NB-1:0]   lanes_q;
  logic            write_q;

  logic            accept;
  logic            addr_err;
  logic [LB-1:0]   offset;
  logic [LB-1:0]   align_mask;
  logic [NB-1:0]   lanes;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] rdata;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  assign offset = HADDR[LB-1:0];
  assign accept = HSEL & HTRANS[1] & HREADY;

  always_comb begin
    align_mask = LB'((32'd1 << HSIZE) - 32'd1);
    // 2**HSIZE consecutive lanes from the byte offset; junk when HSIZE is
    // oversized, but that case is flagged as an error and never written.
    lanes      = NB'(((32'd1 << (32'd1 << HSIZE)) - 32'd1) << offset);
    addr_err   = (HADDR >= MemBytes) || (HSIZE > 3'(LB)) || ((offset & align_mask) != '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StData;
      end
      StErr1: state_d = StErr2;
      default: begin
        // StIdle, StData and StErr2 all complete a phase and may accept.
        if (!accept) begin
          state_d = StIdle;
        end else if (addr_err) begin
          state_d = StErr1;
        end else if (WAIT_STATES == 0) begin
          state_d = StData;
        end else begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      lanes_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= HADDR[LB +: AW];
        lanes_q <= lanes;
        write_q <= HWRITE;
      end
    end
  end

  // The edge that ends DATA commits; the same edge may register a new index.
  assign be = (state_q == StData && write_q) ? lanes_q : '0;

  ahb3_sram_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .be_i    (be),
    .waddr_i (idx_q),
    .wdata_i (HWDATA),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

  assign HREADY = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign HRESP  = (state_q == StErr1 || state_q == StErr2) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA = (state_q == StWait || state_q == StData) ? rdata : '0;

endmodule

// File: tb/tb_ahb3_sram_responder.sv
// Bench for ahb3_sram_responder: one zero-wait instance and one 3-wait
// instance share the bus signals; HSEL steers transfers to one of them.
module tb_ahb3_sram_responder;
  import ahb3_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned PLEN  = 32;
  localparam int unsigned DEPTH = 64;
  localparam int MemBytes = DEPTH * 8;
  localparam int KNone = 0;
  localparam int KOk   = 1;
  localparam int KErr  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        which = 1'b0;
  logic [31:0] haddr = '0;
  logic [63:0] hwdata = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic [3:0]  hprot = '0;
  logic [1:0]  htrans = '0;
  logic        hmastlock = 1'b0;
  logic        hsel0, hsel1;
  logic        hready0, hresp0, hready1, hresp1;
  logic [63:0] hrdata0, hrdata1;

  assign hsel0 = sel & ~which;
  assign hsel1 = sel & which;

  ahb3_sram_responder #(.XLEN(XLEN), .PLEN(PLEN), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata0),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HREADY(hready0), .HRESP(hresp0)
  );

  ahb3_sram_responder #(.XLEN(XLEN), .PLEN(PLEN), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .HSEL(hsel1), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata1),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HREADY(hready1), .HRESP(hresp1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Transfer-level model: each instance has at most one outstanding data
  // phase, described by its kind, remaining wait cycles and error phase.
  logic [63:0] mmem   [2][DEPTH];
  logic [7:0]  mknown [2][DEPTH];
  int          m_kind [2];
  int          m_wait [2];
  int          m_idx  [2];
  logic        m_errph[2];
  logic [7:0]  m_lanes[2];
  logic        m_wr   [2];

  function automatic logic m_rdy(input int k);
    if (m_kind[k] == KOk) return m_wait[k] == 0;
    if (m_kind[k] == KErr) return m_errph[k];
    return 1'b1;
  endfunction

  function automatic logic m_resp(input int k);
    return m_kind[k] == KErr;
  endfunction

  function automatic logic [63:0] m_mask(input int k);
    logic [63:0] m;
    m = '1;
    if (m_kind[k] == KOk) begin
      for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{mknown[k][m_idx[k]][b]}};
    end
    return m;
  endfunction

  function automatic logic [63:0] m_rdata(input int k);
    if (m_kind[k] == KOk) return mmem[k][m_idx[k]] & m_mask(k);
    return '0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_kind[k]  = KNone;
      m_wait[k]  = 0;
      m_idx[k]   = 0;
      m_errph[k] = 1'b0;
      m_lanes[k] = '0;
      m_wr[k]    = 1'b0;
    end
  endtask

  task automatic m_step(input int k);
    logic s;
    int   ws, nbytes, a;
    logic err;
    s  = (k == 0) ? hsel0 : hsel1;
    ws = (k == 0) ? 0 : 3;
    if (m_rdy(k)) begin
      if (m_kind[k] == KOk && m_wr[k]) begin
        for (int b = 0; b < 8; b++) begin
          if (m_lanes[k][b]) begin
            mmem[k][m_idx[k]][b*8 +: 8] = hwdata[b*8 +: 8];
            mknown[k][m_idx[k]][b] = 1'b1;
          end
        end
      end
      if (s && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)) begin
        a      = int'(haddr);
        nbytes = 1 << int'(hsize);
        err    = (a >= MemBytes) || (hsize > 3'd3) || ((a % nbytes) != 0);
        m_errph[k] = 1'b0;
        m_wr[k]    = hwrite;
        m_wait[k]  = ws;
        if (err) begin
          m_kind[k] = KErr;
        end else begin
          m_kind[k]  = KOk;
          m_idx[k]   = a / 8;
          m_lanes[k] = 8'(((1 << nbytes) - 1) << (a % 8));
        end
      end else begin
        m_kind[k] = KNone;
      end
    end else if (m_kind[k] == KOk) begin
      m_wait[k]--;
    end else begin
      m_errph[k] = 1'b1;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) for (int w = 0; w < DEPTH; w++) mknown[k][w] = '0;
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else for (int k = 0; k < 2; k++) m_step(k);
    end
  end

  // Per-cycle compare of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("ready%0d", k), {63'd0, (k == 0) ? hready0 : hready1}, {63'd0, m_rdy(k)});
          chk($sformatf("resp%0d", k), {63'd0, (k == 0) ? hresp0 : hresp1}, {63'd0, m_resp(k)});
          chk($sformatf("rdata%0d", k), ((k == 0) ? hrdata0 : hrdata1) & m_mask(k), m_rdata(k));
        end
      end
    end
  end

  logic [63:0] pend_wd = '0;
  int          last_stall = 0;
  int          stall_sum = 0;

  // Advance to the next rising edge at which the selected responder is ready.
  task automatic wait_ready();
    int   stalls;
    logic r;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r = which ? hready1 : hready0;
      @(posedge clk);
      #1;
      if (r) begin
        last_stall = stalls;
        return;
      end
      stalls++;
    end
    n_cmp++;
    n_err++;
    $display("FAIL ready_timeout: got %0d low cycles, expected ready within 40", stalls);
    last_stall = stalls;
  endtask

  // One address phase; HWDATA carries the previous transfer's data.
  task automatic bus(input logic s, input logic [1:0] tr, input logic w, input logic [31:0] a,
                     input logic [2:0] sz, input logic [63:0] wd);
    sel     = s;
    htrans  = tr;
    hwrite  = w;
    haddr   = a;
    hsize   = sz;
    hwdata  = pend_wd;
    pend_wd = wd;
    wait_ready();
  endtask

  task automatic idle();
    bus(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_BYTE, 64'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, hready0}, 64'd1);
    chk("reset_resp", {63'd0, hresp0}, 64'd0);
    chk("reset_rdata", hrdata0, 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait write then back-to-back reads.
    which = 1'b0;
    bus(1'b1, HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_DWORD, 64'h0123456789ABCDEF);
    stall_sum = last_stall;
    bus(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_DWORD, 64'h0);
    stall_sum += last_stall;
    chk("raw_rdata", hrdata0, 64'h0123456789ABCDEF);
    bus(1'b1, HTRANS_NONSEQ, 1'b1, 32'h43, HSIZE_BYTE, 64'h00000000AA000000);
    stall_sum += last_stall;
    bus(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_DWORD, 64'h0);
    stall_sum += last_stall;
    chk("byte_rdata", hrdata0, 64'h01234567AAABCDEF);
    idle();
    stall_sum += last_stall;
    chk("ws0_no_stall", 64'(stall_sum), 64'd0);

    // Out-of-range read: two-cycle ERROR.
    bus(1'b1, HTRANS_NONSEQ, 1'b0, 32'(MemBytes), HSIZE_DWORD, 64'h0);
    chk("err1_ready", {63'd0, hready0}, 64'd0);
    chk("err1_resp", {63'd0, hresp0}, 64'd1);
    sel = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = pend_wd;
    pend_wd = '0;
    @(posedge clk);
    #1;
    chk("err2_ready", {63'd0, hready0}, 64'd1);
    chk("err2_resp", {63'd0, hresp0}, 64'd1);
    idle();

    // Misaligned halfword write, then a read held through ERR1.
    bus(1'b1, HTRANS_NONSEQ, 1'b1, 32'h41, HSIZE_HWORD, 64'h0000000000BEEF00);
    bus(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_DWORD, 64'h0);
    chk("err_stall", 64'(last_stall), 64'd1);
    chk("err_nowrite", hrdata0, 64'h01234567AAABCDEF);
    // Oversized transfer.
    bus(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, 3'd4, 64'h0);
    idle();
    idle();

    // Inactive transfers inside a burst and with HSEL low.
    stall_sum = 0;
    bus(1'b1, HTRANS_NONSEQ, 1'b1, 32'h58, HSIZE_DWORD, 64'hDDDDDDDD44444444);
    stall_sum += last_stall;
    bus(1'b1, HTRANS_NONSEQ, 1'b1, 32'h48, HSIZE_DWORD, 64'hA1A2A3A4A5A6A7A8);
    stall_sum += last_stall;
    bus(1'b1, HTRANS_BUSY, 1'b1, 32'h50, HSIZE_DWORD, 64'hBAD0BAD0BAD0BAD0);
    stall_sum += last_stall;
    bus(1'b1, HTRANS_SEQ, 1'b1, 32'h50, HSIZE_DWORD, 64'hB1B2B3B4B5B6B7B8);
    stall_sum += last_stall;
    bus(1'b1, HTRANS_IDLE, 1'b1, 32'h58, HSIZE_DWORD, 64'hBAD1BAD1BAD1BAD1);
    stall_sum += last_stall;
    bus(1'b0, HTRANS_NONSEQ, 1'b1, 32'h58, HSIZE_DWORD, 64'hCCCCCCCCCCCCCCCC);
    stall_sum += last_stall;
    bus(1'b1, HTRANS_NONSEQ, 1'b0, 32'h48, HSIZE_DWORD, 64'h0);
    chk("burst_rd48", hrdata0, 64'hA1A2A3A4A5A6A7A8);
    bus(1'b1, HTRANS_SEQ, 1'b0, 32'h50, HSIZE_DWORD, 64'h0);
    chk("burst_rd50", hrdata0, 64'hB1B2B3B4B5B6B7B8);
    bus(1'b1, HTRANS_NONSEQ, 1'b0, 32'h58, HSIZE_DWORD, 64'h0);
    chk("nosel_rd58", hrdata0, 64'hDDDDDDDD44444444);
    idle();
    stall_sum += last_stall;
    chk("inactive_no_stall", 64'(stall_sum), 64'd0);

    // Three wait states.
    which = 1'b1;
    bus(1'b1, HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_DWORD, 64'h0123456789ABCDEF);
    bus(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_DWORD, 64'h0);
    chk("ws3_wr_stall", 64'(last_stall), 64'd3);
    chk("ws3_wait_ready", {63'd0, hready1}, 64'd0);
    chk("ws3_wait_rdata", hrdata1, 64'h0123456789ABCDEF);
    idle();
    chk("ws3_rd_stall", 64'(last_stall), 64'd3);

    // Reset in the middle of a waited write.
    bus(1'b1, HTRANS_NONSEQ, 1'b1, 32'h60, HSIZE_DWORD, 64'h0F0E0D0C0B0A0908);
    idle();
    bus(1'b1, HTRANS_NONSEQ, 1'b1, 32'h60, HSIZE_DWORD, 64'h5555666677778888);
    sel = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = pend_wd;
    pend_wd = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", {63'd0, hready1}, 64'd1);
    chk("midrst_resp", {63'd0, hresp1}, 64'd0);
    chk("midrst_rdata", hrdata1, 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    bus(1'b1, HTRANS_NONSEQ, 1'b0, 32'h60, HSIZE_DWORD, 64'h0);
    chk("midrst_nowrite", hrdata1, 64'h0F0E0D0C0B0A0908);
    idle();
    idle();

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
